cpu_step_ctrl: RTL and testbench
================================

# cpu_step_ctrl

Clock-enable generator and run controller for the single-cycle ARM core on the FPGA board. It replaces the ripple-divided processor clock with a single-cycle enable pulse on the 50 MHz system clock. The pulse rate is programmable. It adds halt, single-step (debounced pushbutton) and PC-breakpoint modes. `cpu_en_o` drives the register/write enables of `arm`, `dmem` and `led_controller`, which all stay on `clk`.

## Interface
Parameters:
- `DIV_WIDTH`, 26, width of the run-rate divider and `div_i`.
- `DEB_CYCLES`, 1_000_000, cycles the button must be stable to register (20 ms at 50 MHz).
- `PC_WIDTH`, 32, width of `pc_i` and `bp_addr_i`.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: system clock, 50 MHz.
- `reset` in 1: synchronous, active-high.
- `mode_i` in 2: 00 HALT, 01 RUN, 10 STEP, 11 RUN_BP (run with breakpoint).
- `div_i` in DIV_WIDTH: in run modes, one enable every `div_i`+1 cycles; 0 means every cycle.
- `step_btn_i` in 1: raw pushbutton, asynchronous, active-high.
- `pc_i` in PC_WIDTH: current core PC.
- `bp_addr_i` in PC_WIDTH: breakpoint address.
- `cpu_en_o` out 1: registered one-cycle core enable.
- `halted_o` out 1: 1 when the core is not free-running.
- `bp_hit_o` out 1: sticky breakpoint indication.
- `step_count_o` out 16: count of enables issued; wraps 0xFFFF→0.

## Operation
- **Reset values:** state HALT, `cpu_en_o`=0, `halted_o`=1, `bp_hit_o`=0, `step_count_o`=0. Divider counter is 0. Debouncer treats the button as released.
- **States:** HALT, RUN, STEP, BREAK.
  - Outside BREAK, the next state is decoded from `mode_i` every cycle. RUN_BP maps to RUN with breakpoint compare enabled.
- **Divider:**
  - Counts only in RUN.
  - When the count is ≥ `div_i`, a tick fires and the count returns to 0; otherwise it increments.
  - The ≥ compare makes a mid-run decrease of `div_i` tick immediately, never wrap the full range.
  - Any `mode_i` change, or entry to or exit from BREAK, clears the count to 0.
- **RUN:** each tick asserts `cpu_en_o` the next cycle.
- **RUN_BP:**
  - If `pc_i` == `bp_addr_i` in the tick cycle, the tick is suppressed. Next cycle: state BREAK, `bp_hit_o`=1, no enable.
  - The instruction at `bp_addr_i` is not executed.
- **STEP:** each debounced rising edge of `step_btn_i` gives exactly one `cpu_en_o` pulse. Holding the button gives no repeat.
- **BREAK:**
  - A debounced press gives one enable, with no breakpoint compare, then returns to RUN, so the core executes past the breakpoint.
  - If `mode_i` ≠ RUN_BP, BREAK is left to the decoded state.
  - `bp_hit_o` clears on any exit from BREAK.
- `halted_o` = 1 in HALT, STEP and BREAK, and 0 in RUN.
- `step_count_o` increments in the same cycle `cpu_en_o` is high.
- **Simultaneous events:**
  - A `mode_i` change and a tick in the same cycle: the mode change wins, and no enable is issued.
  - A debounced press outside STEP or BREAK is discarded.
- **Reset mid-operation** overrides everything in that cycle. A pending enable is dropped.

## Timing
- `cpu_en_o` is a registered output, high for exactly one cycle; never asserted on back-to-back cycles unless `div_i`=0 in RUN.
- RUN with constant `div_i`=N: first enable N+1 cycles after the mode reaches RUN, then period N+1.
- Button path: 2-flop synchroniser, then a stable-count of DEB_CYCLES, then a rise pulse.
  - Total from a clean press to the rise pulse is 2+DEB_CYCLES+1 cycles.
  - `cpu_en_o` follows the pulse by 1 cycle.
- Glitches shorter than DEB_CYCLES produce no pulse.
- Breakpoint compare is combinational on `pc_i` in the tick cycle. `pc_i` must be stable since the last enable, which holds for the single-cycle core.

## Structure
- Package `cpu_step_pkg`:
  - `mode_t` enum (HALT=2'b00, RUN=2'b01, STEP=2'b10, RUN_BP=2'b11).
  - `state_t` enum.
  - `STEP_CNT_W` = 16.
- Sub-module `btn_debounce` (parameter DEB_CYCLES): synchroniser, stability counter, debounced level and one-cycle rise output.
- Top-level integration: `arm`, `dmem` and `led_controller` all clock on `clk`; their state updates are qualified by `cpu_en_o`.

## Test plan
Benches use DEB_CYCLES=4.
- **Reset values:** reset held 3 cycles with mode=RUN and `div_i`=0 → all outputs at reset values during reset. First `cpu_en_o` 1 cycle after release, then high every cycle; `step_count_o` reaches 10 after 10 enables.
- **Rate and mode change:** RUN with `div_i`=4 → pulses exactly every 5 cycles. Switching `div_i` to 1 while the count is 3 → tick next cycle, then period 2. Mode→HALT coincident with a tick → no enable, `halted_o`=1.
- **STEP debounce:** STEP mode, bounce of 2-cycle pulses, then held 20 cycles → exactly one `cpu_en_o`, 8 cycles after the stable rising edge. Release and press again → second pulse; `step_count_o`=2.
- **Breakpoint:** RUN_BP with `div_i`=2, `bp_addr_i`=0x10, `pc_i` stepping 0x08, 0x0C, 0x10 → two enables, then BREAK with `bp_hit_o`=1 and no further enables for 50 cycles. A press → one enable, `bp_hit_o`=0, RUN resumes.
- **Wrap and reset mid-operation:** force 0xFFFF enables → `step_count_o` wraps to 0. Reset asserted in the tick cycle → no enable; all outputs at reset values next cycle.

Source files
------------

// File: rtl/cpu_step_pkg.sv
// Shared types and helpers for the CPU clock-enable / run controller.
package cpu_step_pkg;

  typedef enum logic [1:0] {
    HALT   = 2'b00,
    RUN    = 2'b01,
    STEP   = 2'b10,
    RUN_BP = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    ST_HALT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STEP  = 2'b10,
    ST_BREAK = 2'b11
  } state_t;

  localparam int STEP_CNT_W = 16;

  // RUN_BP shares the RUN state; the breakpoint compare is gated by the mode itself.
  function automatic state_t decode_mode(mode_t m);
    case (m)
      RUN, RUN_BP: return ST_RUN;
      STEP:        return ST_STEP;
      default:     return ST_HALT;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-flop synchroniser, stability counter, debounced
// level and a one-cycle pulse on each debounced rising edge.
module btn_debounce #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic rise_o
);

  localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             level;
  logic             level_q;
  logic [CNT_W-1:0] stable_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0    <= 1'b0;
      sync_p1    <= 1'b0;
      level      <= 1'b0;
      level_q    <= 1'b0;
      stable_cnt <= '0;
      rise_o     <= 1'b0;
    end else begin
      sync_p0 <= btn_i;
      sync_p1 <= sync_p0;
      level_q <= level;
      rise_o  <= level & ~level_q;
      // Level flips only after DEB_CYCLES consecutive samples disagree with it.
      if (sync_p1 == level) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CNT_LAST) begin
        level      <= sync_p1;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_step_ctrl.sv
// Run controller for the single-cycle core: one-cycle enable pulses on clk with
// programmable rate, halt, debounced single-step and PC breakpoint.
module cpu_step_ctrl
  import cpu_step_pkg::*;
#(
  parameter int DIV_WIDTH  = 26,
  parameter int DEB_CYCLES = 1_000_000,
  parameter int PC_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            mode_i,
  input  logic [DIV_WIDTH-1:0]  div_i,
  input  logic                  step_btn_i,
  input  logic [PC_WIDTH-1:0]   pc_i,
  input  logic [PC_WIDTH-1:0]   bp_addr_i,
  output logic                  cpu_en_o,
  output logic                  halted_o,
  output logic                  bp_hit_o,
  output logic [STEP_CNT_W-1:0] step_count_o
);

  state_t               state;
  state_t               mode_state;
  logic [1:0]           mode_q;
  logic [DIV_WIDTH-1:0] div_cnt;
  logic                 step_rise;
  logic                 mode_chg;
  logic                 tick;
  logic                 bp_match;

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_btn (
    .clk   (clk),
    .reset (reset),
    .btn_i (step_btn_i),
    .rise_o(step_rise)
  );

  assign mode_state = decode_mode(mode_t'(mode_i));
  assign mode_chg   = (mode_i != mode_q);
  // >= rather than == so a lowered div_i ticks at once instead of wrapping.
  assign tick       = (state == ST_RUN) && !mode_chg && (div_cnt >= div_i);
  assign bp_match   = (mode_i == RUN_BP) && (pc_i == bp_addr_i);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_HALT;
      mode_q       <= HALT;
      div_cnt      <= '0;
      cpu_en_o     <= 1'b0;
      halted_o     <= 1'b1;
      bp_hit_o     <= 1'b0;
      step_count_o <= '0;
    end else begin
      mode_q   <= mode_i;
      cpu_en_o <= 1'b0;
      div_cnt  <= '0;
      bp_hit_o <= 1'b0;
      state    <= mode_state;
      halted_o <= (mode_state != ST_RUN);
      case (state)
        ST_RUN: begin
          if (!mode_chg) begin
            if (!tick) begin
              div_cnt <= div_cnt + 1'b1;
            end else if (bp_match) begin
              // Suppress the tick so the breakpoint instruction is not executed.
              state    <= ST_BREAK;
              halted_o <= 1'b1;
              bp_hit_o <= 1'b1;
            end else begin
              cpu_en_o     <= 1'b1;
              step_count_o <= step_count_o + 1'b1;
            end
          end
        end
        ST_STEP: begin
          if (step_rise && !mode_chg) begin
            cpu_en_o     <= 1'b1;
            step_count_o <= step_count_o + 1'b1;
          end
        end
        ST_BREAK: begin
          if (mode_i == RUN_BP) begin
            if (step_rise) begin
              // Execute the breakpoint instruction without re-comparing, then run on.
              cpu_en_o     <= 1'b1;
              step_count_o <= step_count_o + 1'b1;
              state        <= ST_RUN;
              halted_o     <= 1'b0;
            end else begin
              state    <= ST_BREAK;
              halted_o <= 1'b1;
              bp_hit_o <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Bench for cpu_step_ctrl: vector table, hand-written corner sequences and
// randomized stimulus against a behavioural model.
module tb_cpu_step_ctrl;
  import cpu_step_pkg::*;

  localparam int DIV_W = 26;
  localparam int DEB   = 4;

  logic             clk;
  logic             rst;
  logic [1:0]       mode;
  logic [DIV_W-1:0] div_v;
  logic             btn;
  logic [31:0]      pc;
  logic [31:0]      bp;
  logic             cpu_en;
  logic             halted;
  logic             bp_hit;
  logic [15:0]      step_count;

  cpu_step_ctrl #(
    .DIV_WIDTH (DIV_W),
    .DEB_CYCLES(DEB),
    .PC_WIDTH  (32)
  ) dut (
    .clk         (clk),
    .reset       (rst),
    .mode_i      (mode),
    .div_i       (div_v),
    .step_btn_i  (btn),
    .pc_i        (pc),
    .bp_addr_i   (bp),
    .cpu_en_o    (cpu_en),
    .halted_o    (halted),
    .bp_hit_o    (bp_hit),
    .step_count_o(step_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_model = 1'b0;

  task automatic check_bit(string name, bit act, bit exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  int m_st;          // 0 halted, 1 running, 2 stepping, 3 at breakpoint
  int m_elapsed;     // cycles spent running since the last tick or entry
  int m_prev_mode;
  bit m_en, m_halted, m_hit;
  int m_count;
  bit btn_hist[$];   // raw button value sampled at each edge
  bit m_level, m_up_q, m_rise;

  function automatic int mode_home(int m);
    if (m == 0) return 0;
    if (m == 2) return 2;
    return 1;
  endfunction

  task automatic model_step();
    bit press, changed, flip;
    if (rst) begin
      m_st = 0; m_elapsed = 0; m_prev_mode = 0;
      m_en = 0; m_halted = 1; m_hit = 0; m_count = 0;
      btn_hist.delete();
      for (int i = 0; i < DEB + 2; i++) btn_hist.push_back(1'b0);
      m_level = 0; m_up_q = 0; m_rise = 0;
      return;
    end
    // The synchronised button lags the raw one by two edges; the level flips once
    // DEB successive synchronised samples all differ from it.
    btn_hist.push_back(btn);
    while (btn_hist.size() > DEB + 2) void'(btn_hist.pop_front());
    flip = 1'b1;
    for (int i = 0; i < DEB; i++) if (btn_hist[i] == m_level) flip = 1'b0;
    press  = m_rise;
    m_rise = m_up_q;
    m_up_q = flip && !m_level;
    if (flip) m_level = !m_level;

    changed = (int'(mode) != m_prev_mode);
    m_prev_mode = int'(mode);
    m_en  = 0;
    m_hit = 0;
    case (m_st)
      1: begin
        if (changed) begin
          m_st = mode_home(int'(mode));
        end else if (m_elapsed >= int'(div_v)) begin
          m_elapsed = 0;
          if (mode == 2'b11 && pc == bp) begin m_st = 3; m_hit = 1; end
          else m_en = 1;
        end else begin
          m_elapsed++;
        end
      end
      2: begin
        m_en = press && !changed;
        m_st = mode_home(int'(mode));
      end
      3: begin
        if (mode != 2'b11) m_st = mode_home(int'(mode));
        else if (press) begin m_en = 1; m_st = 1; end
        else m_hit = 1;
      end
      default: m_st = mode_home(int'(mode));
    endcase
    if (m_st != 1 || changed) m_elapsed = 0;
    m_halted = (m_st != 1);
    if (m_en) m_count = (m_count + 1) % 65536;
  endtask

  task automatic tick_clk();
    model_step();
    @(posedge clk);
    #1;
    if (chk_model) begin
      check_bit("rnd_en", cpu_en, m_en);
      check_bit("rnd_halted", halted, m_halted);
      check_bit("rnd_bp_hit", bp_hit, m_hit);
      check_int("rnd_count", int'(step_count), m_count);
    end
  endtask

  task automatic do_reset(int n);
    rst = 1'b1;
    for (int i = 0; i < n; i++) tick_clk();
    rst = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit       rst;
    bit [1:0] mode;
    int       div;
    bit       en;
    bit       halted;
    bit       hit;
    int       count;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit r, bit [1:0] m, int d, bit e, bit h, bit bh, int c);
    vec_t v;
    v.rst = r; v.mode = m; v.div = d; v.en = e; v.halted = h; v.hit = bh; v.count = c;
    vecs.push_back(v);
  endfunction

  int en_seen;
  int seg_left;
  int btn_left;

  initial begin
    rst = 1'b1; mode = HALT; div_v = '0; btn = 1'b0; pc = '0; bp = '0;

    // Reset with RUN/div 0, then every-cycle enables, then div 4, div 1, HALT on a tick.
    for (int i = 0; i < 3; i++) add(1'b1, RUN, 0, 1'b0, 1'b1, 1'b0, 0);
    add(1'b0, RUN, 0, 1'b0, 1'b0, 1'b0, 0);
    for (int i = 1; i <= 10; i++) add(1'b0, RUN, 0, 1'b1, 1'b0, 1'b0, i);
    for (int i = 0; i < 4; i++) add(1'b0, RUN, 4, 1'b0, 1'b0, 1'b0, 10);
    add(1'b0, RUN, 4, 1'b1, 1'b0, 1'b0, 11);
    for (int i = 0; i < 4; i++) add(1'b0, RUN, 4, 1'b0, 1'b0, 1'b0, 11);
    add(1'b0, RUN, 4, 1'b1, 1'b0, 1'b0, 12);
    for (int i = 0; i < 3; i++) add(1'b0, RUN, 4, 1'b0, 1'b0, 1'b0, 12);
    add(1'b0, RUN, 1, 1'b1, 1'b0, 1'b0, 13);
    add(1'b0, RUN, 1, 1'b0, 1'b0, 1'b0, 13);
    add(1'b0, RUN, 1, 1'b1, 1'b0, 1'b0, 14);
    add(1'b0, RUN, 1, 1'b0, 1'b0, 1'b0, 14);
    add(1'b0, RUN, 1, 1'b1, 1'b0, 1'b0, 15);
    add(1'b0, RUN, 1, 1'b0, 1'b0, 1'b0, 15);
    add(1'b0, HALT, 1, 1'b0, 1'b1, 1'b0, 15);
    add(1'b0, HALT, 1, 1'b0, 1'b1, 1'b0, 15);

    for (int i = 0; i < vecs.size(); i++) begin
      rst   = vecs[i].rst;
      mode  = vecs[i].mode;
      div_v = DIV_W'(vecs[i].div);
      tick_clk();
      check_bit($sformatf("tbl%0d_en", i), cpu_en, vecs[i].en);
      check_bit($sformatf("tbl%0d_halted", i), halted, vecs[i].halted);
      check_bit($sformatf("tbl%0d_hit", i), bp_hit, vecs[i].hit);
      check_int($sformatf("tbl%0d_count", i), int'(step_count), vecs[i].count);
    end

    // STEP: bounce, then a held press gives one enable 8 cycles later.
    mode = STEP; btn = 1'b0;
    do_reset(2);
    for (int i = 0; i < 3; i++) tick_clk();
    check_bit("step_halted", halted, 1'b1);
    en_seen = 0;
    for (int b = 0; b < 3; b++) begin
      btn = 1'b1; tick_clk(); en_seen += int'(cpu_en); tick_clk(); en_seen += int'(cpu_en);
      btn = 1'b0; tick_clk(); en_seen += int'(cpu_en); tick_clk(); en_seen += int'(cpu_en);
    end
    check_int("step_bounce_en", en_seen, 0);
    btn = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick_clk();
      check_bit($sformatf("step_press1_k%0d", k), cpu_en, k == 8);
    end
    check_int("step_count1", int'(step_count), 1);
    btn = 1'b0;
    en_seen = 0;
    for (int k = 0; k < 10; k++) begin tick_clk(); en_seen += int'(cpu_en); end
    check_int("step_release_en", en_seen, 0);
    btn = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick_clk();
      check_bit($sformatf("step_press2_k%0d", k), cpu_en, k == 8);
    end
    check_int("step_count2", int'(step_count), 2);
    btn = 1'b0;

    // Breakpoint at 0x10 with div 2: two enables, BREAK, then a press resumes.
    mode = RUN_BP; div_v = DIV_W'(2); bp = 32'h10; pc = 32'h08;
    do_reset(2);
    for (int k = 1; k <= 10; k++) begin
      tick_clk();
      check_bit($sformatf("bp_run_k%0d", k), cpu_en, (k == 4) || (k == 7));
      if (k == 4 || k == 7) pc = pc + 32'd4;
    end
    check_bit("bp_hit_set", bp_hit, 1'b1);
    check_bit("bp_halted", halted, 1'b1);
    check_int("bp_count", int'(step_count), 2);
    en_seen = 0;
    for (int k = 0; k < 50; k++) begin tick_clk(); en_seen += int'(cpu_en); end
    check_int("bp_idle_en", en_seen, 0);
    check_bit("bp_hit_hold", bp_hit, 1'b1);
    btn = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      tick_clk();
      check_bit($sformatf("bp_resume_k%0d", k), cpu_en, (k == 8) || (k == 11));
      if (k == 8) begin
        check_bit("bp_hit_clr", bp_hit, 1'b0);
        check_bit("bp_resume_halted", halted, 1'b0);
        check_int("bp_resume_count", int'(step_count), 3);
        pc  = pc + 32'd4;
        btn = 1'b0;
      end
    end
    check_int("bp_after_count", int'(step_count), 4);

    // Randomized run against the model.
    chk_model = 1'b1;
    btn = 1'b0; pc = '0; seg_left = 0; btn_left = 0;
    do_reset(2);
    for (int c = 0; c < 3000; c++) begin
      if (seg_left == 0) begin
        mode  = 2'($urandom_range(0, 3));
        div_v = DIV_W'($urandom_range(0, 4));
        case ($urandom_range(0, 2))
          0:       bp = 32'h10;
          1:       bp = 32'h20;
          default: bp = 32'h2C;
        endcase
        seg_left = $urandom_range(5, 60);
      end
      seg_left--;
      if ($urandom_range(0, 39) == 0) div_v = DIV_W'($urandom_range(0, 4));
      if (btn_left == 0) begin btn = ~btn; btn_left = $urandom_range(1, 12); end
      btn_left--;
      rst = ($urandom_range(0, 499) == 0);
      tick_clk();
      if (m_en) pc = (pc + 32'd4) & 32'h3F;
    end
    chk_model = 1'b0;
    rst = 1'b0; btn = 1'b0;

    // Counter wrap, then reset landing on a tick cycle.
    mode = RUN; div_v = '0;
    do_reset(2);
    tick_clk();
    for (int k = 0; k < 65535; k++) tick_clk();
    check_int("wrap_ffff", int'(step_count), 65535);
    tick_clk();
    check_int("wrap_zero", int'(step_count), 0);
    check_bit("wrap_en", cpu_en, 1'b1);
    div_v = DIV_W'(3);
    for (int k = 0; k < 3; k++) begin
      tick_clk();
      check_bit($sformatf("pre_rst_en_%0d", k), cpu_en, 1'b0);
    end
    check_bit("pre_rst_halted", halted, 1'b0);
    rst = 1'b1;
    tick_clk();
    check_bit("rst_tick_en", cpu_en, 1'b0);
    check_bit("rst_tick_halted", halted, 1'b1);
    check_bit("rst_tick_hit", bp_hit, 1'b0);
    check_int("rst_tick_count", int'(step_count), 0);
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
